// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC fetch front end.
package wisc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam logic [OP_HI-OP_LO:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FS_REQ    = 2'd0,
        FS_WAIT   = 2'd1,
        FS_HOLD   = 2'd2,
        FS_HALTED = 2'd3
    } fetch_state_e;

    // One IF/ID payload: instruction word and the address following it.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc_plus1;
    } ifid_t;

    function automatic logic is_hlt(input logic [DATA_W-1:0] word);
        return word[OP_HI:OP_LO] == OP_HLT;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
interface instr_fetch_if;
    import wisc_pkg::*;

    logic              imem_rd;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_rdy;
    logic [DATA_W-1:0] imem_instr;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_rdy,
        input  imem_instr
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_rdy,
        output imem_instr
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module if_hold_buf
    import wisc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  logic  clear_i,
    input  ifid_t data_i,
    output ifid_t data_o,
    output logic  full_o
);

    ifid_t data_q;
    logic  full_q;

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory requests, stall buffering,
// branch redirect with stale-response squashing, and HLT detection.
module instr_fetch
    import wisc_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_target,
    instr_fetch_if.master     imem,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_plus1,
    output logic              valid,
    output logic              fetch_halted
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              stale_q, stale_d;
    logic              rd_c;

    logic              buf_load, buf_clear, buf_full;
    ifid_t             buf_q, fetched;
    logic [DATA_W-1:0] pc_inc;

    assign pc_inc  = pc_q + DATA_W'(1);
    assign fetched = '{instr: imem.imem_instr, pc_plus1: pc_inc};

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (fetched),
        .data_o  (buf_q),
        .full_o  (buf_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FS_REQ;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_REQ:    if (!stall && !stale_q) state_d = FS_WAIT;
            FS_WAIT:   if (imem.imem_rdy) begin
                           if (stall)                            state_d = FS_HOLD;
                           else if (is_hlt(imem.imem_instr))     state_d = FS_HALTED;
                           else                                  state_d = FS_REQ;
                       end
            FS_HOLD:   if (!stall && buf_full)
                           state_d = is_hlt(buf_q.instr) ? FS_HALTED : FS_REQ;
            FS_HALTED: state_d = FS_HALTED;
            default:   state_d = FS_REQ;
        endcase
        if (br_taken) state_d = FS_REQ;
    end

    // No new request goes out while a squashed response is still in flight.
    always_comb begin
        rd_c      = 1'b0;
        pc_d      = pc_q;
        ifid_d    = ifid_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        stale_d   = stale_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (imem.imem_rdy) stale_d = 1'b0;
        case (state_q)
            FS_REQ: begin
                rd_c = !stall && !stale_q && !br_taken;
                if (!stall) valid_d = 1'b0;
            end
            FS_WAIT: begin
                rd_c = 1'b1;
                if (imem.imem_rdy) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        buf_load = 1'b1;
                    end else begin
                        ifid_d   = fetched;
                        valid_d  = 1'b1;
                        halted_d = is_hlt(imem.imem_instr);
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            FS_HOLD: begin
                if (!stall && buf_full) begin
                    ifid_d    = buf_q;
                    valid_d   = 1'b1;
                    buf_clear = 1'b1;
                    halted_d  = is_hlt(buf_q.instr);
                end
            end
            FS_HALTED: if (!stall) valid_d = 1'b0;
            default: ;
        endcase
        if (br_taken) begin
            pc_d      = br_target;
            valid_d   = 1'b0;
            buf_load  = 1'b0;
            buf_clear = 1'b1;
            halted_d  = 1'b0;
            if (state_q == FS_WAIT && !imem.imem_rdy) stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RST_PC;
            ifid_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            stale_q  <= stale_d;
        end
    end

    // Request is gated by reset so the bus is quiet while rst_n is low.
    assign imem.imem_rd   = rd_c & rst_n;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr_out      = ifid_q.instr;
    assign pc_plus1       = ifid_q.pc_plus1;
    assign valid          = valid_q;
    assign fetch_halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized stall/branch traffic
// checked against an in-order instruction-stream model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic [15:0] instr_out;
    logic [15:0] pc_plus1;
    logic        valid;
    logic        fetch_halted;

    instr_fetch_if imem_bus ();

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .imem         (imem_bus),
        .pc           (pc),
        .instr_out    (instr_out),
        .pc_plus1     (pc_plus1),
        .valid        (valid),
        .fetch_halted (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: word array, fixed or random latency, one request at a time.
    logic [15:0] mem [0:65535];
    int          lat_fix;
    int          rnd_lat;
    int          cur_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [15:0] mem_addr;

    always @(negedge clk) rnd_lat <= $urandom_range(1, 3);
    assign cur_lat = (lat_fix != 0) ? lat_fix : rnd_lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_busy            <= 1'b0;
            mem_cnt             <= 0;
            mem_addr            <= '0;
            imem_bus.imem_rdy   <= 1'b0;
            imem_bus.imem_instr <= '0;
        end else begin
            imem_bus.imem_rdy <= 1'b0;
            if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    imem_bus.imem_rdy   <= 1'b1;
                    imem_bus.imem_instr <= mem[mem_addr];
                    mem_busy            <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end else if (imem_bus.imem_rd && !imem_bus.imem_rdy) begin
                if (cur_lat == 1) begin
                    imem_bus.imem_rdy   <= 1'b1;
                    imem_bus.imem_instr <= mem[imem_bus.imem_addr];
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= cur_lat - 1;
                    mem_addr <= imem_bus.imem_addr;
                end
            end
        end
    end

    // Stream model: every word decode accepts must be the next sequential one
    // since the last redirect; a consumed HLT means fetch must already be halted.
    logic        sb_en = 1'b0;
    logic [15:0] exp_pc;
    int          n_cons = 0;

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (imem_bus.imem_rd) check("rnd_addr_eq_pc", 32'(imem_bus.imem_addr), 32'(pc));
            if (fetch_halted) begin
                check("rnd_halt_no_rd", 32'(imem_bus.imem_rd), 0);
                check("rnd_halt_pc", 32'(pc), 32'(16'(exp_pc + (valid ? 16'd1 : 16'd0))));
            end
            if (br_taken) begin
                exp_pc = br_target;
            end else if (!stall && valid) begin
                check("rnd_instr", 32'(instr_out), 32'(mem[exp_pc]));
                check("rnd_pc_plus1", 32'(pc_plus1), 32'(16'(exp_pc + 16'd1)));
                if (mem[exp_pc][15:12] == 4'hF) check("rnd_hlt_halted", 32'(fetch_halted), 1);
                exp_pc = 16'(exp_pc + 16'd1);
                n_cons++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic br(input logic [15:0] t);
        br_taken  = 1'b1;
        br_target = t;
        tick();
        br_taken  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(valid), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        lat_fix   = 1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i & 32'h0FFF);

        repeat (3) tick();
        check("rst_pc", 32'(pc), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_instr", 32'(instr_out), 0);
        check("rst_pc_plus1", 32'(pc_plus1), 0);
        check("rst_halted", 32'(fetch_halted), 0);
        check("rst_rd", 32'(imem_bus.imem_rd), 0);

        rst_n = 1'b1;
        #1;
        check("first_rd", 32'(imem_bus.imem_rd), 1);
        check("first_addr", 32'(imem_bus.imem_addr), 0);

        // L=1 back-to-back fetch: one word every two cycles.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("seq_bubble", 32'(valid), 0);
            tick();
            check("seq_valid", 32'(valid), 1);
            check("seq_instr", 32'(instr_out), 32'(k));
            check("seq_pc_plus1", 32'(pc_plus1), 32'(k + 1));
        end

        // Stall across the response: word buffered, delivered once.
        lat_fix = 2;
        tick();
        stall = 1'b1;
        tick();
        check("stall_valid", 32'(valid), 0);
        check("stall_instr_hold", 32'(instr_out), 2);
        check("stall_wait_rd", 32'(imem_bus.imem_rd), 1);
        tick();
        check("hold_rd", 32'(imem_bus.imem_rd), 0);
        check("hold_pc", 32'(pc), 4);
        check("hold_valid", 32'(valid), 0);
        tick();
        stall = 1'b0;
        tick();
        check("unstall_valid", 32'(valid), 1);
        check("unstall_instr", 32'(instr_out), 3);
        check("unstall_pc_plus1", 32'(pc_plus1), 4);
        check("unstall_next_addr", 32'(imem_bus.imem_addr), 4);

        // Redirect while a response is outstanding.
        tick();
        br_taken  = 1'b1;
        br_target = 16'h0040;
        tick();
        br_taken = 1'b0;
        lat_fix  = 1;
        #1;
        check("stale_rd_blocked", 32'(imem_bus.imem_rd), 0);
        check("stale_pc", 32'(pc), 32'h40);
        check("stale_valid", 32'(valid), 0);
        tick();
        check("redir_rd", 32'(imem_bus.imem_rd), 1);
        check("redir_addr", 32'(imem_bus.imem_addr), 32'h40);
        wait_valid("redir_wait");
        check("redir_instr", 32'(instr_out), 32'h40);
        check("redir_pc_plus1", 32'(pc_plus1), 32'h41);

        // HLT word halts fetch until redirect.
        mem[5] = 16'hF000;
        br(16'h0005);
        wait_valid("hlt_wait");
        check("hlt_instr", 32'(instr_out), 32'hF000);
        check("hlt_pc_plus1", 32'(pc_plus1), 6);
        check("hlt_halted", 32'(fetch_halted), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hlt_rd_idle", 32'(imem_bus.imem_rd), 0);
        end
        check("hlt_pc_frozen", 32'(pc), 6);
        check("hlt_still", 32'(fetch_halted), 1);
        check("hlt_bubble", 32'(valid), 0);
        br(16'h0010);
        check("resume_unhalted", 32'(fetch_halted), 0);
        wait_valid("resume_wait");
        check("resume_instr", 32'(instr_out), 32'h10);

        // Address wrap.
        br(16'hFFFF);
        wait_valid("wrap_wait");
        check("wrap_instr", 32'(instr_out), 32'h0FFF);
        check("wrap_pc_plus1", 32'(pc_plus1), 0);
        check("wrap_rd", 32'(imem_bus.imem_rd), 1);
        check("wrap_addr", 32'(imem_bus.imem_addr), 0);

        // Reset while waiting on memory.
        br(16'h0200);
        wait_valid("prerst_wait");
        check("prerst_instr", 32'(instr_out), 32'h200);
        lat_fix = 3;
        tick();
        check("prerst_rd", 32'(imem_bus.imem_rd), 1);
        check("prerst_addr", 32'(imem_bus.imem_addr), 32'h201);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pc", 32'(pc), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_instr", 32'(instr_out), 0);
        check("midrst_pc_plus1", 32'(pc_plus1), 0);
        check("midrst_halted", 32'(fetch_halted), 0);
        check("midrst_rd", 32'(imem_bus.imem_rd), 0);
        repeat (4) tick();
        rst_n = 1'b1;
        #1;
        check("postrst_rd", 32'(imem_bus.imem_rd), 1);
        check("postrst_addr", 32'(imem_bus.imem_addr), 0);

        // Random traffic against the stream model.
        lat_fix = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        sb_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            stall    = ($urandom_range(0, 99) < 30);
            br_taken = (c == 0) || ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 7) == 0) br_target = 16'(16'hFFFC + 16'($urandom_range(0, 7)));
            else                           br_target = 16'($urandom);
            tick();
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        tick();
        sb_en = 1'b0;
        check("rnd_progress", 32'(n_cons > 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
